regfile_scoreboard: RTL and testbench



---
 rtl/regfile_scoreboard_if.sv | 30 +++
 rtl/regfile_scoreboard.sv | 111 +++++++++++
 tb/tb_regfile_scoreboard.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// Register-file bus: two read ports with pending flags, one write port, one claim port.
// master = pipeline controller side, slave = register file side.
interface regfile_scoreboard_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              ready;
   logic [ADDR_W-1:0] rd_addr1;
   logic [ADDR_W-1:0] rd_addr2;
   logic [DATA_W-1:0] rd_data1;
   logic [DATA_W-1:0] rd_data2;
   logic              rd_pend1;
   logic              rd_pend2;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              claim_en;
   logic [ADDR_W-1:0] claim_addr;
   logic [ADDR_W:0]   pend_cnt;

   modport master (
      output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, claim_en, claim_addr,
      input  ready, rd_data1, rd_data2, rd_pend1, rd_pend2, pend_cnt
   );

   modport slave (
      input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, claim_en, claim_addr,
      output ready, rd_data1, rd_data2, rd_pend1, rd_pend2, pend_cnt
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// MIPS GPR file: 2 async reads, 1 sync write, per-register pending scoreboard,
// and a post-reset clear sequencer that zeroes every register before use.
module regfile_scoreboard #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                clk,
   input  logic                rst,
   regfile_scoreboard_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_W;

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_RUN   = 1'b1;

   localparam logic [ADDR_W-1:0] PTR_ONE = 1;
   localparam logic [ADDR_W:0]   CNT_ONE = 1;

   logic [0:0]        state;
   logic [ADDR_W-1:0] clr_ptr;
   logic              ready_q;
   logic [DEPTH-1:0]  pend;
   logic [ADDR_W:0]   pend_cnt_q;
   logic [DATA_W-1:0] mem [DEPTH];

   logic wr_ok;
   logic claim_ok;
   logic claim_set;
   logic wr_clr;

   function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   assign wr_ok    = ready_q && bus.wr_en && !is_zero_reg(bus.wr_addr);
   assign claim_ok = ready_q && bus.claim_en && !is_zero_reg(bus.claim_addr);

   // A claim to the register being written keeps it pending: a new producer was issued.
   assign claim_set = claim_ok && !pend[bus.claim_addr];
   assign wr_clr    = wr_ok && pend[bus.wr_addr] &&
                      !(claim_ok && (bus.claim_addr == bus.wr_addr));

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_CLEAR;
         clr_ptr    <= '0;
         ready_q    <= 1'b0;
         pend       <= '0;
         pend_cnt_q <= '0;
      end else begin
         case (state)
            ST_CLEAR: begin
               clr_ptr <= clr_ptr + PTR_ONE;
               if (&clr_ptr) begin
                  state   <= ST_RUN;
                  ready_q <= 1'b1;
               end
            end
            default: begin
               if (wr_clr)
                  pend[bus.wr_addr] <= 1'b0;
               if (claim_set)
                  pend[bus.claim_addr] <= 1'b1;
               case ({claim_set, wr_clr})
                  2'b10:   pend_cnt_q <= pend_cnt_q + CNT_ONE;
                  2'b01:   pend_cnt_q <= pend_cnt_q - CNT_ONE;
                  default: pend_cnt_q <= pend_cnt_q;
               endcase
            end
         endcase
      end
   end

   // Storage carries no reset; the clear sequencer owns zeroing it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == ST_CLEAR)
            mem[clr_ptr] <= '0;
         else if (wr_ok)
            mem[bus.wr_addr] <= bus.wr_data;
      end
   end

   always_comb begin
      bus.rd_data1 = '0;
      if (ready_q && !is_zero_reg(bus.rd_addr1)) begin
         if ((BYPASS != 0) && wr_ok && (bus.wr_addr == bus.rd_addr1))
            bus.rd_data1 = bus.wr_data;
         else
            bus.rd_data1 = mem[bus.rd_addr1];
      end
   end

   always_comb begin
      bus.rd_data2 = '0;
      if (ready_q && !is_zero_reg(bus.rd_addr2)) begin
         if ((BYPASS != 0) && wr_ok && (bus.wr_addr == bus.rd_addr2))
            bus.rd_data2 = bus.wr_data;
         else
            bus.rd_data2 = mem[bus.rd_addr2];
      end
   end

   assign bus.rd_pend1 = ready_q && pend[bus.rd_addr1];
   assign bus.rd_pend2 = ready_q && pend[bus.rd_addr2];
   assign bus.ready    = ready_q;
   assign bus.pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: a bypassing and a non-bypassing instance share stimulus
// and are compared against an array-based model of the register file and scoreboard.
module tb_regfile_scoreboard;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   regfile_scoreboard_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
   regfile_scoreboard_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_nb ();

   assign bus_nb.rd_addr1   = bus.rd_addr1;
   assign bus_nb.rd_addr2   = bus.rd_addr2;
   assign bus_nb.wr_en      = bus.wr_en;
   assign bus_nb.wr_addr    = bus.wr_addr;
   assign bus_nb.wr_data    = bus.wr_data;
   assign bus_nb.claim_en   = bus.claim_en;
   assign bus_nb.claim_addr = bus.claim_addr;

   regfile_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1), .BYPASS(1)) dut (
      .clk(clk), .rst(rst), .bus(bus.slave));

   regfile_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1), .BYPASS(0)) dut_nb (
      .clk(clk), .rst(rst), .bus(bus_nb.slave));

   // Reference model
   logic [DATA_W-1:0] mem_m [DEPTH];
   bit                pend_m [DEPTH];
   int                since_rst = 0;
   bit                model_known = 1'b0;

   int nvec  = 0;
   int nfail = 0;

   function automatic bit ready_m();
      return since_rst >= DEPTH;
   endfunction

   function automatic int cnt_m();
      int s = 0;
      for (int i = 0; i < DEPTH; i++) s += int'(pend_m[i]);
      return s;
   endfunction

   function automatic logic [DATA_W-1:0] exp_rd(input logic [ADDR_W-1:0] a, input bit byp);
      if (!ready_m() || a == 0) return '0;
      if (byp && bus.wr_en && bus.wr_addr == a && bus.wr_addr != 0) return bus.wr_data;
      return mem_m[a];
   endfunction

   function automatic logic exp_pend(input logic [ADDR_W-1:0] a);
      return ready_m() ? logic'(pend_m[a]) : 1'b0;
   endfunction

   task automatic idle();
      bus.wr_en      = 1'b0;
      bus.wr_addr    = '0;
      bus.wr_data    = '0;
      bus.claim_en   = 1'b0;
      bus.claim_addr = '0;
   endtask

   task automatic comb_check();
      if (!model_known) return;
      nvec++;
      if (bus.rd_data1 !== exp_rd(bus.rd_addr1, 1'b1)) begin
         nfail++;
         $display("FAIL rd_data1 addr=%0d got=%h want=%h", bus.rd_addr1, bus.rd_data1, exp_rd(bus.rd_addr1, 1'b1));
      end
      nvec++;
      if (bus.rd_data2 !== exp_rd(bus.rd_addr2, 1'b1)) begin
         nfail++;
         $display("FAIL rd_data2 addr=%0d got=%h want=%h", bus.rd_addr2, bus.rd_data2, exp_rd(bus.rd_addr2, 1'b1));
      end
      nvec++;
      if (bus.rd_pend1 !== exp_pend(bus.rd_addr1)) begin
         nfail++;
         $display("FAIL rd_pend1 addr=%0d got=%b want=%b", bus.rd_addr1, bus.rd_pend1, exp_pend(bus.rd_addr1));
      end
      nvec++;
      if (bus.rd_pend2 !== exp_pend(bus.rd_addr2)) begin
         nfail++;
         $display("FAIL rd_pend2 addr=%0d got=%b want=%b", bus.rd_addr2, bus.rd_pend2, exp_pend(bus.rd_addr2));
      end
      nvec++;
      if (bus_nb.rd_data1 !== exp_rd(bus.rd_addr1, 1'b0)) begin
         nfail++;
         $display("FAIL nb_rd_data1 addr=%0d got=%h want=%h", bus.rd_addr1, bus_nb.rd_data1, exp_rd(bus.rd_addr1, 1'b0));
      end
      nvec++;
      if (bus_nb.rd_data2 !== exp_rd(bus.rd_addr2, 1'b0)) begin
         nfail++;
         $display("FAIL nb_rd_data2 addr=%0d got=%h want=%h", bus.rd_addr2, bus_nb.rd_data2, exp_rd(bus.rd_addr2, 1'b0));
      end
   endtask

   task automatic edge_step();
      @(posedge clk);
      if (rst) begin
         since_rst   = 0;
         model_known = 1'b1;
         for (int i = 0; i < DEPTH; i++) begin
            pend_m[i] = 1'b0;
            mem_m[i]  = '0;
         end
      end else begin
         if (ready_m()) begin
            if (bus.wr_en && bus.wr_addr != 0) begin
               mem_m[bus.wr_addr]  = bus.wr_data;
               pend_m[bus.wr_addr] = 1'b0;
            end
            if (bus.claim_en && bus.claim_addr != 0)
               pend_m[bus.claim_addr] = 1'b1;
         end
         if (since_rst < 1000) since_rst++;
      end
      #1;
      if (!model_known) return;
      nvec++;
      if (bus.ready !== ready_m() || bus_nb.ready !== ready_m()) begin
         nfail++;
         $display("FAIL ready got=%b/%b want=%b", bus.ready, bus_nb.ready, ready_m());
      end
      nvec++;
      if (bus.pend_cnt !== (ADDR_W+1)'(cnt_m()) || bus_nb.pend_cnt !== (ADDR_W+1)'(cnt_m())) begin
         nfail++;
         $display("FAIL pend_cnt got=%0d/%0d want=%0d", bus.pend_cnt, bus_nb.pend_cnt, cnt_m());
      end
   endtask

   task automatic tick();
      @(negedge clk);
      comb_check();
      edge_step();
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         bus.rd_addr1   = ADDR_W'($urandom_range(0, DEPTH-1));
         bus.rd_addr2   = ADDR_W'($urandom_range(0, DEPTH-1));
         bus.wr_en      = 1'b1;
         bus.wr_addr    = 5'd12;
         bus.wr_data    = $urandom | 32'h1;
         bus.claim_en   = 1'b1;
         bus.claim_addr = ADDR_W'($urandom_range(1, DEPTH-1));
         tick();
         if (bus.ready === 1'b1) begin
            n = i;
            break;
         end
      end
      idle();
   endtask

   task automatic test_reset();
      int n;
      idle();
      bus.rd_addr1 = '0;
      bus.rd_addr2 = '0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      wait_ready(n);
      nvec++;
      if (n != DEPTH) begin
         nfail++;
         $display("FAIL ready_latency got=%0d want=%0d", n, DEPTH);
      end
      for (int a = 0; a < DEPTH; a++) begin
         bus.rd_addr1 = ADDR_W'(a);
         bus.rd_addr2 = ADDR_W'(DEPTH-1-a);
         @(negedge clk);
         comb_check();
         nvec++;
         if (bus.rd_data1 !== 32'h0 || bus.rd_data2 !== 32'h0) begin
            nfail++;
            $display("FAIL cleared_read addr=%0d got=%h/%h want=0", a, bus.rd_data1, bus.rd_data2);
         end
         edge_step();
      end
      nvec++;
      if (bus.pend_cnt !== 6'd0) begin
         nfail++;
         $display("FAIL reset_pend_cnt got=%0d want=0", bus.pend_cnt);
      end
   endtask

   task automatic test_bypass();
      idle();
      bus.wr_en    = 1'b1;
      bus.wr_addr  = 5'd5;
      bus.wr_data  = 32'hDEADBEEF;
      bus.rd_addr1 = 5'd5;
      @(negedge clk);
      comb_check();
      nvec++;
      if (bus.rd_data1 !== 32'hDEADBEEF) begin
         nfail++;
         $display("FAIL bypass_same_cycle got=%h want=deadbeef", bus.rd_data1);
      end
      nvec++;
      if (bus_nb.rd_data1 !== 32'h0) begin
         nfail++;
         $display("FAIL nobypass_same_cycle got=%h want=00000000", bus_nb.rd_data1);
      end
      edge_step();
      idle();
      @(negedge clk);
      comb_check();
      nvec++;
      if (bus_nb.rd_data1 !== 32'hDEADBEEF) begin
         nfail++;
         $display("FAIL nobypass_next_cycle got=%h want=deadbeef", bus_nb.rd_data1);
      end
      edge_step();
   endtask

   task automatic test_zero_reg();
      idle();
      bus.wr_en      = 1'b1;
      bus.wr_addr    = 5'd0;
      bus.wr_data    = 32'h12345678;
      bus.claim_en   = 1'b1;
      bus.claim_addr = 5'd0;
      bus.rd_addr1   = 5'd0;
      @(negedge clk);
      comb_check();
      nvec++;
      if (bus.rd_data1 !== 32'h0 || bus.rd_pend1 !== 1'b0) begin
         nfail++;
         $display("FAIL r0_same_cycle got=%h/%b want=0/0", bus.rd_data1, bus.rd_pend1);
      end
      edge_step();
      idle();
      @(negedge clk);
      comb_check();
      nvec++;
      if (bus.rd_data1 !== 32'h0 || bus.rd_pend1 !== 1'b0 || bus.pend_cnt !== 6'd0) begin
         nfail++;
         $display("FAIL r0_after got=%h/%b/%0d want=0/0/0", bus.rd_data1, bus.rd_pend1, bus.pend_cnt);
      end
      edge_step();
   endtask

   task automatic test_claims();
      logic [5:0] want [3] = '{6'd1, 6'd2, 6'd2};
      logic [4:0] regs [3] = '{5'd3, 5'd7, 5'd3};
      for (int i = 0; i < 3; i++) begin
         idle();
         bus.claim_en   = 1'b1;
         bus.claim_addr = regs[i];
         tick();
         nvec++;
         if (bus.pend_cnt !== want[i]) begin
            nfail++;
            $display("FAIL claim_cnt step=%0d got=%0d want=%0d", i, bus.pend_cnt, want[i]);
         end
      end
      idle();
      bus.wr_en   = 1'b1;
      bus.wr_addr = 5'd3;
      bus.wr_data = 32'hA5;
      tick();
      nvec++;
      if (bus.pend_cnt !== 6'd1) begin
         nfail++;
         $display("FAIL write_release_cnt got=%0d want=1", bus.pend_cnt);
      end
      idle();
      bus.rd_addr1 = 5'd3;
      bus.rd_addr2 = 5'd7;
      @(negedge clk);
      comb_check();
      nvec++;
      if (bus.rd_pend1 !== 1'b0 || bus.rd_data1 !== 32'hA5 || bus.rd_pend2 !== 1'b1) begin
         nfail++;
         $display("FAIL write_release got=%b/%h/%b want=0/000000a5/1", bus.rd_pend1, bus.rd_data1, bus.rd_pend2);
      end
      edge_step();
   endtask

   task automatic test_same_cycle();
      idle();
      bus.claim_en   = 1'b1;
      bus.claim_addr = 5'd9;
      bus.wr_en      = 1'b1;
      bus.wr_addr    = 5'd9;
      bus.wr_data    = 32'h55;
      tick();
      nvec++;
      if (bus.pend_cnt !== 6'd2) begin
         nfail++;
         $display("FAIL claim_write_cnt got=%0d want=2", bus.pend_cnt);
      end
      idle();
      bus.rd_addr1 = 5'd9;
      @(negedge clk);
      comb_check();
      nvec++;
      if (bus.rd_pend1 !== 1'b1 || bus.rd_data1 !== 32'h55) begin
         nfail++;
         $display("FAIL claim_write got=%b/%h want=1/00000055", bus.rd_pend1, bus.rd_data1);
      end
      edge_step();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         bus.rd_addr1   = ADDR_W'($urandom_range(0, 11));
         bus.rd_addr2   = ($urandom_range(0, 3) == 0) ? bus.rd_addr1 : ADDR_W'($urandom_range(0, DEPTH-1));
         bus.wr_en      = ($urandom_range(0, 1) == 1);
         bus.wr_addr    = ADDR_W'($urandom_range(0, 11));
         bus.wr_data    = $urandom;
         bus.claim_en   = ($urandom_range(0, 9) < 4);
         bus.claim_addr = ADDR_W'($urandom_range(0, 11));
         tick();
      end
      idle();
   endtask

   task automatic test_reset_mid_clear();
      int n;
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         bus.wr_en   = 1'b1;
         bus.wr_addr = 5'd12;
         bus.wr_data = $urandom;
         tick();
      end
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wait_ready(n);
      nvec++;
      if (n != DEPTH) begin
         nfail++;
         $display("FAIL restart_latency got=%0d want=%0d", n, DEPTH);
      end
      bus.rd_addr1 = 5'd12;
      bus.rd_addr2 = 5'd9;
      @(negedge clk);
      comb_check();
      nvec++;
      if (bus.rd_data1 !== 32'h0 || bus.rd_data2 !== 32'h0 || bus.pend_cnt !== 6'd0) begin
         nfail++;
         $display("FAIL clear_window_write got=%h/%h/%0d want=0/0/0", bus.rd_data1, bus.rd_data2, bus.pend_cnt);
      end
      edge_step();
   endtask

   initial begin
      rst = 1'b1;
      idle();
      bus.rd_addr1 = '0;
      bus.rd_addr2 = '0;
      #1;
      test_reset();
      test_bypass();
      test_zero_reg();
      test_claims();
      test_same_cycle();
      test_random();
      test_reset_mid_clear();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
endmodule
